// File: rtl/vga_sync_tracker.sv
// Purpose: recover sync-relative pixel/line position from hsync/vsync, measure line and frame lengths, and lock onto nominal timing.
// Latency: every output is registered and updates on the clk edge whose pix_en sample detects the event.
// Backpressure: none; the block follows the incoming video, and pix_en low freezes all state except single-clk pulses.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   pix_en          pixel tick qualifier; sampling and counting happen only when high
//   hsync, vsync    incoming syncs, asserted level set by SYNC_POL
//   x_pos, y_pos    ticks since the last hsync edge, and hsync edges since the last vsync edge
//   h_period        last measured line length in ticks
//   v_lines         last measured frame length in lines
//   locked          timing has matched H_TOTAL/V_TOTAL for LOCK_FRAMES consecutive frames
//   frame_start     1-clk pulse on each vsync assertion edge
//   err             1-clk pulse when lock is lost (bad measurement or timeout)
module vga_sync_tracker #(
    parameter int   H_TOTAL     = 800,
    parameter int   V_TOTAL     = 525,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [9:0] h_period,
    output logic [9:0] v_lines,
    output logic       locked,
    output logic       frame_start,
    output logic       err
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0]  CNT_MAX = 10'd1023;
    localparam logic [10:0] H_NOM   = 11'(H_TOTAL);
    localparam logic [10:0] V_NOM   = 11'(V_TOTAL);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    state_t      state;
    logic [3:0]  good;
    logic        hs_q;
    logic        vs_q;
    logic        line_bad;

    logic        hs_edge;
    logic        vs_edge;
    logic [10:0] h_meas;
    logic [10:0] v_meas;
    logic        h_bad;
    logic        v_good;
    logic        frame_ok;
    logic [9:0]  x_nxt;
    logic [9:0]  y_nxt;
    logic [9:0]  y_inc;
    logic [3:0]  good_inc;
    logic        tmo;

    always_comb begin
        hs_edge  = pix_en && (hsync == SYNC_POL) && (hs_q != SYNC_POL);
        vs_edge  = pix_en && (vsync == SYNC_POL) && (vs_q != SYNC_POL);
        // Measurements are one bit wider so a saturated counter (1023+1) can never alias a nominal value.
        h_meas   = {1'b0, x_pos} + 11'd1;
        h_bad    = hs_edge && (h_meas != H_NOM);
        // A line closed on the same tick as the vsync edge belongs to the frame being closed.
        v_meas   = hs_edge ? ({1'b0, y_pos} + 11'd1) : {1'b0, y_pos};
        v_good   = (v_meas == V_NOM);
        frame_ok = !line_bad && !h_bad && v_good;
        x_nxt    = hs_edge ? 10'd0 : ((x_pos == CNT_MAX) ? CNT_MAX : x_pos + 10'd1);
        y_inc    = (y_pos == CNT_MAX) ? CNT_MAX : y_pos + 10'd1;
        y_nxt    = vs_edge ? 10'd0 : (hs_edge ? y_inc : y_pos);
        good_inc = good + 4'd1;
        // Only the transition into saturation counts, so a stuck counter fires once rather than
        // pinning the FSM in SEARCH forever.
        tmo      = ((x_nxt == CNT_MAX) && (x_pos != CNT_MAX)) ||
                   ((y_nxt == CNT_MAX) && (y_pos != CNT_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos       <= '0;
            y_pos       <= '0;
            h_period    <= '0;
            v_lines     <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            state       <= SEARCH;
            good        <= '0;
            line_bad    <= 1'b0;
            // Deasserted history means a sync already asserted at reset release is seen as a fresh edge,
            // and a deasserted one produces nothing.
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
        end else begin
            frame_start <= 1'b0;
            err         <= 1'b0;
            if (pix_en) begin
                hs_q     <= hsync;
                vs_q     <= vsync;
                x_pos    <= x_nxt;
                y_pos    <= y_nxt;
                line_bad <= vs_edge ? 1'b0 : (line_bad | h_bad);
                if (hs_edge) begin
                    h_period <= h_meas[9:0];
                end
                if (vs_edge) begin
                    v_lines     <= v_meas[9:0];
                    frame_start <= 1'b1;
                end

                if (tmo) begin
                    if (state == LOCKED) begin
                        err <= 1'b1;
                    end
                    state  <= SEARCH;
                    good   <= '0;
                    locked <= 1'b0;
                end else begin
                    case (state)
                        SEARCH: begin
                            // The frame in progress here started at an unknown point and is never scored.
                            if (vs_edge) begin
                                state <= VERIFY;
                                good  <= '0;
                            end
                        end
                        VERIFY: begin
                            if (vs_edge) begin
                                if (frame_ok) begin
                                    good <= good_inc;
                                    if (good_inc == LOCK_N) begin
                                        state  <= LOCKED;
                                        locked <= 1'b1;
                                    end
                                end else begin
                                    good <= '0;
                                end
                            end
                        end
                        LOCKED: begin
                            if (h_bad || (vs_edge && !v_good)) begin
                                err    <= 1'b1;
                                locked <= 1'b0;
                                state  <= SEARCH;
                                good   <= '0;
                            end
                        end
                        default: begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            good   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
